// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// Optional lock-loss counter is enabled with PLL_LOCK_LOSS_CNT_EN.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAIL      = 3'd5
    } seq_state_e;

    localparam int unsigned LOCK_LOSS_CNT_W = 8;

    // Shared timer must hold the longest interval the sequencer measures.
    function automatic int unsigned seq_cnt_width(input int unsigned lock_timeout,
                                                  input int unsigned stable_cycles,
                                                  input int unsigned release_span);
        int unsigned m;
        m = lock_timeout;
        if (stable_cycles > m) m = stable_cycles;
        if (release_span > m) m = release_span;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// PLL-side and domain-side signals of the reset sequencer.
// lock_loss_cnt exists only when PLL_LOCK_LOSS_CNT_EN is defined.
interface pll_reset_sequencer_if #(
    parameter int unsigned NUM_DOMAINS = 3
);
    import pll_seq_pkg::*;

    logic                   pll_locked;
    logic                   soft_reset;
    logic                   pll_areset;
    logic [NUM_DOMAINS-1:0] dom_reset_n;
    logic                   ready;
    logic                   fail;
    logic [2:0]             state_dbg;
`ifdef PLL_LOCK_LOSS_CNT_EN
    logic [LOCK_LOSS_CNT_W-1:0] lock_loss_cnt;
`endif

    modport master (
        input  pll_locked,
        input  soft_reset,
        output pll_areset,
        output dom_reset_n,
        output ready,
        output fail,
        output state_dbg
`ifdef PLL_LOCK_LOSS_CNT_EN
        , output lock_loss_cnt
`endif
    );

    modport slave (
        output pll_locked,
        output soft_reset,
        input  pll_areset,
        input  dom_reset_n,
        input  ready,
        input  fail,
        input  state_dbg
`ifdef PLL_LOCK_LOSS_CNT_EN
        , input lock_loss_cnt
`endif
    );

endinterface

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Single-bit two-flop synchronizer, async active-low reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up and staggered domain reset release sequencer.
// Define PLL_LOCK_LOSS_CNT_EN to add the saturating lock_loss_cnt output.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS    = 3,
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 50000,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned STAGE_GAP      = 16,
    parameter int unsigned MAX_RETRIES    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    pll_reset_sequencer_if.master bus
);

    localparam int unsigned CNT_W = seq_cnt_width(LOCK_TIMEOUT, STABLE_CYCLES,
                                                  NUM_DOMAINS * STAGE_GAP);
    localparam int unsigned RTY_W = $clog2(MAX_RETRIES + 1);
    localparam int unsigned IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(STAGE_GAP - 1);
    localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRIES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DOMAINS - 1);

    seq_state_e             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [RTY_W-1:0]       r_retries;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_pll_areset;
    logic [NUM_DOMAINS-1:0] r_dom_reset_n;
    logic                   r_ready;
    logic                   r_fail;
    logic                   w_locked_s;

    sync_2ff u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (bus.pll_locked),
        .o_q     (w_locked_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= PLL_RST;
            r_cnt         <= '0;
            r_retries     <= '0;
            r_idx         <= '0;
            r_pll_areset  <= 1'b1;
            r_dom_reset_n <= '0;
            r_ready       <= 1'b0;
            r_fail        <= 1'b0;
        end else begin
            case (r_state)
                PLL_RST: begin
                    r_pll_areset <= 1'b1;
                    if (r_cnt == RST_LAST) begin
                        r_state      <= WAIT_LOCK;
                        r_cnt        <= '0;
                        r_pll_areset <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (w_locked_s) begin
                        r_state <= STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == TMO_LAST) begin
                        r_cnt     <= '0;
                        r_retries <= r_retries + RTY_W'(1);
                        if (r_retries == RTY_LAST) begin
                            r_state      <= FAIL;
                            r_fail       <= 1'b1;
                            r_pll_areset <= 1'b0;
                        end else begin
                            r_state      <= PLL_RST;
                            r_pll_areset <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                STABLE: begin
                    if (!w_locked_s) begin
                        r_state <= WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (bus.soft_reset) begin
                        r_cnt <= '0;
                    end else if (r_cnt == STB_LAST) begin
                        r_state <= RELEASE;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RELEASE, RUN: begin
                    // Lock loss outranks soft reset; both drop every domain at once.
                    if (!w_locked_s) begin
                        r_state       <= WAIT_LOCK;
                        r_cnt         <= '0;
                        r_dom_reset_n <= '0;
                        r_ready       <= 1'b0;
                    end else if (bus.soft_reset) begin
                        r_state       <= STABLE;
                        r_cnt         <= '0;
                        r_dom_reset_n <= '0;
                        r_ready       <= 1'b0;
                    end else if (r_state == RELEASE) begin
                        if (r_cnt == GAP_LAST) begin
                            r_cnt         <= '0;
                            r_dom_reset_n <= (r_dom_reset_n << 1) | NUM_DOMAINS'(1);
                            r_idx         <= r_idx + IDX_W'(1);
                            if (r_idx == IDX_LAST) begin
                                r_state   <= RUN;
                                r_ready   <= 1'b1;
                                r_retries <= '0;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                FAIL: begin
                    r_pll_areset  <= 1'b0;
                    r_fail        <= 1'b1;
                    r_dom_reset_n <= '0;
                    r_ready       <= 1'b0;
                end
                default: begin
                    r_state      <= PLL_RST;
                    r_cnt        <= '0;
                    r_pll_areset <= 1'b1;
                end
            endcase
        end
    end

`ifdef PLL_LOCK_LOSS_CNT_EN
    logic                       r_locked_q;
    logic [LOCK_LOSS_CNT_W-1:0] r_lock_loss_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_locked_q      <= 1'b0;
            r_lock_loss_cnt <= '0;
        end else begin
            r_locked_q <= w_locked_s;
            if (r_locked_q && !w_locked_s && r_lock_loss_cnt != '1 &&
                (r_state == STABLE || r_state == RELEASE || r_state == RUN)) begin
                r_lock_loss_cnt <= r_lock_loss_cnt + LOCK_LOSS_CNT_W'(1);
            end
        end
    end

    assign bus.lock_loss_cnt = r_lock_loss_cnt;
`endif

    assign bus.pll_areset  = r_pll_areset;
    assign bus.dom_reset_n = r_dom_reset_n;
    assign bus.ready       = r_ready;
    assign bus.fail        = r_fail;
    assign bus.state_dbg   = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer; expected domain-reset steps are queued
// by each scenario and matched at the exact edge by a negedge monitor.
module tb_pll_reset_sequencer;

    localparam int unsigned NUM_DOMAINS    = 3;
    localparam int unsigned PLL_RST_CYCLES = 4;
    localparam int unsigned LOCK_TIMEOUT   = 32;
    localparam int unsigned STABLE_CYCLES  = 8;
    localparam int unsigned STAGE_GAP      = 2;
    localparam int unsigned MAX_RETRIES    = 2;
    localparam int unsigned SYNC_LAT       = 2;

    typedef struct {
        logic [2:0]  dom;
        logic        rdy;
        int unsigned cyc;
    } exp_t;

    logic        clk;
    logic        reset_n;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    bit          mon_en = 1'b0;
    logic [2:0]  prev_dom = '0;
    exp_t        exp_q[$];
    exp_t        mon_e;

    pll_reset_sequencer_if #(.NUM_DOMAINS(NUM_DOMAINS)) bus ();

    pll_reset_sequencer #(
        .NUM_DOMAINS    (NUM_DOMAINS),
        .PLL_RST_CYCLES (PLL_RST_CYCLES),
        .LOCK_TIMEOUT   (LOCK_TIMEOUT),
        .STABLE_CYCLES  (STABLE_CYCLES),
        .STAGE_GAP      (STAGE_GAP),
        .MAX_RETRIES    (MAX_RETRIES)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en && bus.dom_reset_n !== prev_dom) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL dom_unexpected: dom_reset_n=%b ready=%b at cycle %0d, no step required",
                         bus.dom_reset_n, bus.ready, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.dom_reset_n !== mon_e.dom || bus.ready !== mon_e.rdy || cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL dom_step: got dom_reset_n=%b ready=%b cycle %0d, required dom_reset_n=%b ready=%b cycle %0d",
                             bus.dom_reset_n, bus.ready, cyc, mon_e.dom, mon_e.rdy, mon_e.cyc);
                end
            end
        end
        prev_dom = bus.dom_reset_n;
    end

    task automatic wait_until(input int unsigned k);
        while (cyc < k) @(negedge clk);
    endtask

    // q: edge after which the stable counter holds 0 with lock qualified.
    task automatic push_release(input int unsigned q);
        exp_t        e;
        int unsigned t;
        for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
            t     = (1 << (i + 1)) - 1;
            e.dom = t[2:0];
            e.rdy = (i == NUM_DOMAINS - 1);
            e.cyc = q + STABLE_CYCLES + STAGE_GAP * (i + 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_reset(output int unsigned r);
        @(negedge clk);
        mon_en         = 1'b0;
        reset_n        = 1'b0;
        bus.pll_locked = 1'b0;
        bus.soft_reset = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        r       = cyc + 1;
        mon_en  = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (bus.pll_areset !== 1'b1) begin errors++; $display("FAIL reset_areset: got %b, required 1", bus.pll_areset); end
        checks++; if (bus.dom_reset_n !== 3'b000) begin errors++; $display("FAIL reset_dom: got %b, required 000", bus.dom_reset_n); end
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, required 0", bus.ready); end
        checks++; if (bus.fail !== 1'b0) begin errors++; $display("FAIL reset_fail: got %b, required 0", bus.fail); end
        checks++; if (bus.state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d, required 0", bus.state_dbg); end
    endtask

    task automatic test_nominal();
        int unsigned r;
        @(negedge clk);
        reset_n = 1'b1;
        r       = cyc + 1;
        mon_en  = 1'b1;
        for (int unsigned k = r; k < r + PLL_RST_CYCLES - 1; k++) begin
            wait_until(k);
            checks++; if (bus.pll_areset !== 1'b1) begin errors++; $display("FAIL nom_areset_hi: got %b at cycle %0d, required 1", bus.pll_areset, cyc); end
        end
        wait_until(r + PLL_RST_CYCLES - 1);
        checks++; if (bus.pll_areset !== 1'b0) begin errors++; $display("FAIL nom_areset_lo: got %b, required 0", bus.pll_areset); end
        checks++; if (bus.state_dbg !== 3'd1) begin errors++; $display("FAIL nom_wait_state: got %0d, required 1", bus.state_dbg); end
        wait_until(r + 9);
        bus.pll_locked = 1'b1;
        push_release(r + 10 + SYNC_LAT);
        drain(80);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL nom_drain: %0d steps outstanding, required 0", exp_q.size()); exp_q.delete(); end
        checks++; if (bus.ready !== 1'b1 || bus.state_dbg !== 3'd4) begin errors++; $display("FAIL nom_run: ready=%b state=%0d, required ready=1 state=4", bus.ready, bus.state_dbg); end
    endtask

    task automatic test_lock_loss_run();
        int unsigned l;
        exp_t        e;
        @(negedge clk);
        l     = cyc + 1;
        e.dom = '0; e.rdy = 1'b0; e.cyc = l + SYNC_LAT;
        exp_q.push_back(e);
        bus.pll_locked = 1'b0;
        wait_until(l + SYNC_LAT);
        checks++; if (bus.state_dbg !== 3'd1 || bus.ready !== 1'b0) begin errors++; $display("FAIL loss_state: state=%0d ready=%b, required state=1 ready=0", bus.state_dbg, bus.ready); end
        wait_until(l + 4);
        bus.pll_locked = 1'b1;
        push_release(l + 5 + SYNC_LAT);
        drain(80);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL loss_drain: %0d steps outstanding, required 0", exp_q.size()); exp_q.delete(); end
        checks++; if (bus.pll_areset !== 1'b0) begin errors++; $display("FAIL loss_areset: got %b, required 0", bus.pll_areset); end
    endtask

    task automatic test_soft_reset_run();
        int unsigned s, f;
        exp_t        e;
        @(negedge clk);
        s     = cyc + 1;
        e.dom = '0; e.rdy = 1'b0; e.cyc = s;
        exp_q.push_back(e);
        bus.soft_reset = 1'b1;
        wait_until(s);
        checks++; if (bus.state_dbg !== 3'd2 || bus.ready !== 1'b0) begin errors++; $display("FAIL soft_state: state=%0d ready=%b, required state=2 ready=0", bus.state_dbg, bus.ready); end
        wait_until(s + 4);
        bus.soft_reset = 1'b0;
        f = s + 5;
        push_release(f - 1);
        wait_until(f + STABLE_CYCLES - 2);
        checks++; if (bus.state_dbg !== 3'd2) begin errors++; $display("FAIL soft_hold: state=%0d, required 2", bus.state_dbg); end
        wait_until(f + STABLE_CYCLES - 1);
        checks++; if (bus.state_dbg !== 3'd3) begin errors++; $display("FAIL soft_release: state=%0d, required 3", bus.state_dbg); end
        drain(80);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL soft_drain: %0d steps outstanding, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++; if (bus.dom_reset_n !== 3'b000 || bus.ready !== 1'b0) begin errors++; $display("FAIL mid_reset_dom: dom=%b ready=%b, required dom=000 ready=0", bus.dom_reset_n, bus.ready); end
        checks++; if (bus.pll_areset !== 1'b1 || bus.state_dbg !== 3'd0) begin errors++; $display("FAIL mid_reset_state: areset=%b state=%0d, required areset=1 state=0", bus.pll_areset, bus.state_dbg); end
    endtask

    task automatic test_lock_glitch();
        int unsigned r, g;
        do_reset(r);
        wait_until(r + 9);
        bus.pll_locked = 1'b1;
        g = r + 16;
        wait_until(g - 1);
        bus.pll_locked = 1'b0;
        wait_until(g);
        bus.pll_locked = 1'b1;
        wait_until(g + SYNC_LAT);
        checks++; if (bus.state_dbg !== 3'd1 || bus.pll_areset !== 1'b0) begin errors++; $display("FAIL glitch_wait: state=%0d areset=%b, required state=1 areset=0", bus.state_dbg, bus.pll_areset); end
        push_release(g + 1 + SYNC_LAT);
        wait_until(g + SYNC_LAT + 1);
        checks++; if (bus.state_dbg !== 3'd2 || bus.pll_areset !== 1'b0) begin errors++; $display("FAIL glitch_stable: state=%0d areset=%b, required state=2 areset=0", bus.state_dbg, bus.pll_areset); end
        drain(80);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL glitch_drain: %0d steps outstanding, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_no_lock();
        int unsigned r, t1, t2;
        do_reset(r);
        t1 = r + PLL_RST_CYCLES - 1;
        t2 = t1 + LOCK_TIMEOUT;
        wait_until(t1);
        checks++; if (bus.pll_areset !== 1'b0) begin errors++; $display("FAIL nolock_fall1: areset=%b, required 0", bus.pll_areset); end
        wait_until(t2 - 1);
        checks++; if (bus.pll_areset !== 1'b0 || bus.state_dbg !== 3'd1) begin errors++; $display("FAIL nolock_wait1: areset=%b state=%0d, required areset=0 state=1", bus.pll_areset, bus.state_dbg); end
        wait_until(t2);
        checks++; if (bus.pll_areset !== 1'b1 || bus.state_dbg !== 3'd0) begin errors++; $display("FAIL nolock_pulse2: areset=%b state=%0d, required areset=1 state=0", bus.pll_areset, bus.state_dbg); end
        wait_until(t2 + PLL_RST_CYCLES - 1);
        checks++; if (bus.pll_areset !== 1'b1) begin errors++; $display("FAIL nolock_pulse2_hold: areset=%b, required 1", bus.pll_areset); end
        wait_until(t2 + PLL_RST_CYCLES);
        checks++; if (bus.pll_areset !== 1'b0) begin errors++; $display("FAIL nolock_fall2: areset=%b, required 0", bus.pll_areset); end
        wait_until(t2 + PLL_RST_CYCLES + LOCK_TIMEOUT - 1);
        checks++; if (bus.fail !== 1'b0 || bus.state_dbg !== 3'd1) begin errors++; $display("FAIL nolock_prefail: fail=%b state=%0d, required fail=0 state=1", bus.fail, bus.state_dbg); end
        wait_until(t2 + PLL_RST_CYCLES + LOCK_TIMEOUT);
        checks++; if (bus.fail !== 1'b1 || bus.state_dbg !== 3'd5 || bus.dom_reset_n !== 3'b000 || bus.pll_areset !== 1'b0) begin
            errors++; $display("FAIL nolock_fail: fail=%b state=%0d dom=%b areset=%b, required 1 5 000 0", bus.fail, bus.state_dbg, bus.dom_reset_n, bus.pll_areset);
        end
        wait_until(t2 + PLL_RST_CYCLES + LOCK_TIMEOUT + 100);
        checks++; if (bus.fail !== 1'b1 || bus.state_dbg !== 3'd5 || bus.pll_areset !== 1'b0) begin errors++; $display("FAIL nolock_hold: fail=%b state=%0d areset=%b, required 1 5 0", bus.fail, bus.state_dbg, bus.pll_areset); end
    endtask

`ifdef PLL_LOCK_LOSS_CNT_EN
    task automatic test_lock_loss_cnt();
        int unsigned r;
        do_reset(r);
        wait_until(r + 9);
        bus.pll_locked = 1'b1;
        push_release(r + 10 + SYNC_LAT);
        drain(80);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL llc_drain: %0d steps outstanding, required 0", exp_q.size()); exp_q.delete(); end
        checks++; if (bus.lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL llc_zero: got %0d, required 0", bus.lock_loss_cnt); end
        mon_en = 1'b0;
        for (int unsigned i = 0; i < 300; i++) begin
            @(negedge clk);
            bus.pll_locked = 1'b0;
            repeat (3) @(negedge clk);
            bus.pll_locked = 1'b1;
            repeat (20) @(negedge clk);
            if (i == 0) begin
                checks++; if (bus.lock_loss_cnt !== 8'd1) begin errors++; $display("FAIL llc_first: got %0d, required 1", bus.lock_loss_cnt); end
            end
        end
        checks++; if (bus.lock_loss_cnt !== 8'd255) begin errors++; $display("FAIL llc_sat: got %0d, required 255", bus.lock_loss_cnt); end
        checks++; if (bus.state_dbg !== 3'd4) begin errors++; $display("FAIL llc_run: state=%0d, required 4", bus.state_dbg); end
    endtask
`endif

    initial begin
        reset_n        = 1'b0;
        bus.pll_locked = 1'b0;
        bus.soft_reset = 1'b0;
        test_reset();
        test_nominal();
        test_lock_loss_run();
        test_soft_reset_run();
        test_mid_reset();
        test_lock_glitch();
        test_no_lock();
`ifdef PLL_LOCK_LOSS_CNT_EN
        test_lock_loss_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
